cla_serial_adder: RTL and testbench
===================================

// Module: cla_serial_adder
// PURPOSE
//   Multi-cycle N-bit adder built around one b4_cla_block instance.
//   Latches two N-bit operands and a carry-in on start, then adds one 4-bit
//   nibble per clock, LSB first, chaining each nibble's C_out into the next
//   nibble's C_in through a carry register.
//   Sits directly upstream of and around the 4-bit CLA unit, so wide sums
//   reuse the verified nibble adder instead of a wide combinational tree.
// PARAMETERS
//   N   16   operand/result width in bits; multiple of 4, N >= 4; nibble count NB = N/4
// PORTS
//   clk       in   1   single clock, rising edge
//   rst       in   1   asynchronous, active-high reset
//   start     in   1   request; sampled only while ready=1
//   X         in   N   operand A, sampled on the accepting edge
//   Y         in   N   operand B, sampled on the accepting edge
//   C_in      in   1   carry into bit 0, sampled on the accepting edge
//   ready     out  1   1 when idle and able to accept start
//   done      out  1   one-cycle pulse: Z/C_out/overflow valid from this cycle
//   Z         out  N   registered sum (X + Y + C_in) mod 2^N
//   C_out     out  1   registered carry out of bit N-1
//   overflow  out  1   registered signed overflow of the N-bit sum
// BEHAVIOUR
//   - Reset (async, any time): state=IDLE; ready=1; done=0; Z=0; C_out=0; overflow=0;
//     nibble counter=0; carry reg=0; operand regs=0.
//   - States:
//     - IDLE: ready=1. On start=1, latch X, Y, C_in (carry reg <= C_in), cnt <= 0, go to ADD.
//     - ADD: ready=0. Each edge feeds the low nibble of the operand regs and the carry reg
//       to b4_cla_block.
//       - Nibble sum goes into the accumulator at position cnt; carry reg <= block C_out.
//       - Operand regs shift right by 4; cnt++.
//       - On the edge where cnt == NB-1: Z <= full accumulator (including this nibble),
//         C_out <= block C_out, overflow <= block overflow of this MSB nibble
//         (carry into bit N-1 XOR carry out of bit N-1). Then done <= 1 and go to DONE.
//     - DONE: ready=0; done=1 for exactly this cycle; next edge -> IDLE, done <= 0.
//   - Latency: if start is sampled at edge k, done is high in the cycle after edge k+NB.
//     Next start is accepted at edge k+NB+2 at the earliest. For N=16 that is 4 ADD cycles.
//   - start while ready=0 (ADD or DONE) is ignored; it is neither queued nor causes an abort.
//   - X/Y/C_in changes after the accepting edge do not affect the operation in flight.
//   - Z, C_out and overflow change only on the done edge.
//     They hold the previous result through IDLE and ADD, until the next completion or reset.
//   - Arithmetic wrap: Z is truncated to N bits; the carry beyond bit N-1 appears only on C_out.
//   - Reset mid-ADD: operation aborted, no done pulse, outputs return to reset values.
//   - N=4 degenerate case: single ADD cycle, done in the cycle after edge k+1.
// TESTING  (N=16 unless stated)
//   1. Assert rst, release -> ready=1, done=0, Z=0, C_out=0, overflow=0;
//      rst pulse mid-cycle takes effect without a clock edge.
//   2. X=16'h0FFF, Y=16'h0001, C_in=0, start -> done after 4 ADD cycles,
//      Z=16'h1000, C_out=0, overflow=0 (carry chains across 3 nibbles).
//   3. X=16'hFFFF, Y=16'h0000, C_in=1 -> Z=16'h0000, C_out=1, overflow=0;
//      X=16'h8000, Y=16'h8000, C_in=0 -> Z=16'h0000, C_out=1, overflow=1.
//   4. X=16'h7FFF, Y=16'h0001, C_in=0 -> Z=16'h8000, C_out=0, overflow=1;
//      compare every case against a reference model {C_out,Z} = X+Y+C_in.
//   5. Start A=(16'h1234, 16'h1111); hold start=1 and change X/Y during ADD ->
//      result Z=16'h2345, single done pulse, ready low exactly 5 cycles, no second op.
//   6. Start op, assert rst during 2nd ADD cycle -> no done, Z/C_out/overflow=0, ready=1;
//      next op X=16'h0001, Y=16'h0001 -> Z=16'h0002. Also run N=4 with X=4'hF, Y=4'h1 ->
//      Z=0, C_out=1.

Source files
------------

// File: rtl/cla_serial_adder.sv
// Multi-cycle N-bit adder that reuses a single 4-bit carry-lookahead block.
// It adds one nibble per clock, least significant nibble first, and carries between nibbles through a register.

module b4_cla_block (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c_in,
   output logic [3:0] s,
   output logic       c_out,
   output logic       overflow
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a & b;
   assign p = a ^ b;

   // Every carry is a flat generate/propagate expansion, so there is no ripple path through the nibble.
   assign c[0] = c_in;
   assign c[1] = g[0] | (p[0] & c[0]);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c[0]);

   assign s        = p ^ c[3:0];
   assign c_out    = c[4];
   assign overflow = c[3] ^ c[4];

endmodule

module cla_serial_adder #(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] X,
   input  logic [N-1:0] Y,
   input  logic         C_in,
   output logic         ready,
   output logic         done,
   output logic [N-1:0] Z,
   output logic         C_out,
   output logic         overflow
);

   localparam int NB = N / 4;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [CW-1:0] LAST = CW'(NB - 1);

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t         state;
   logic [N-1:0]   x_reg;
   logic [N-1:0]   y_reg;
   logic [N-1:0]   acc;
   logic [N-1:0]   acc_next;
   logic [CW-1:0]  cnt;
   logic           carry;
   logic [3:0]     blk_s;
   logic           blk_c;
   logic           blk_ovf;

   b4_cla_block u_cla (
      .a        (x_reg[3:0]),
      .b        (y_reg[3:0]),
      .c_in     (carry),
      .s        (blk_s),
      .c_out    (blk_c),
      .overflow (blk_ovf)
   );

   // Merge this cycle's nibble into the accumulator so the final edge can publish the complete sum.
   always_comb begin
      acc_next = acc;
      for (int i = 0; i < NB; i++) begin
         if (cnt == CW'(i)) acc_next[4*i +: 4] = blk_s;
      end
   end

   assign ready = (state == IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         x_reg    <= '0;
         y_reg    <= '0;
         acc      <= '0;
         cnt      <= '0;
         carry    <= 1'b0;
         done     <= 1'b0;
         Z        <= '0;
         C_out    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  x_reg <= X;
                  y_reg <= Y;
                  carry <= C_in;
                  cnt   <= '0;
                  acc   <= '0;
                  state <= ADD;
               end
            end
            ADD: begin
               acc   <= acc_next;
               carry <= blk_c;
               x_reg <= x_reg >> 4;
               y_reg <= y_reg >> 4;
               cnt   <= cnt + 1'b1;
               // The block's overflow is meaningful only on the top nibble, where bit N-1 lives.
               if (cnt == LAST) begin
                  Z        <= acc_next;
                  C_out    <= blk_c;
                  overflow <= blk_ovf;
                  done     <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cla_serial_adder.sv
// Directed bench for cla_serial_adder: runs a 16-bit instance and a 4-bit instance.
// Inputs are driven and outputs are sampled on the falling edge.

module tb_cla_serial_adder;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] x;
   logic [15:0] y;
   logic        c_in;
   logic        ready;
   logic        done;
   logic [15:0] z;
   logic        c_out;
   logic        ovf;

   logic        start4;
   logic [3:0]  x4;
   logic [3:0]  y4;
   logic        c_in4;
   logic        ready4;
   logic        done4;
   logic [3:0]  z4;
   logic        c_out4;
   logic        ovf4;

   int total = 0;
   int bad   = 0;
   int cycles;

   cla_serial_adder #(.N(16)) dut (
      .clk(clk), .rst(rst), .start(start), .X(x), .Y(y), .C_in(c_in),
      .ready(ready), .done(done), .Z(z), .C_out(c_out), .overflow(ovf)
   );

   cla_serial_adder #(.N(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .X(x4), .Y(y4), .C_in(c_in4),
      .ready(ready4), .done(done4), .Z(z4), .C_out(c_out4), .overflow(ovf4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Hand the 16-bit DUT one operation, then wait for done while counting the cycles it takes.
   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic ci);
      @(negedge clk);
      x = a; y = b; c_in = ci; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      x = ~a; y = ~b; c_in = ~ci;
      cycles = 0;
      while (!done && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("latency16", cycles, 4);
   endtask

   task automatic checkResult(input string tag, input logic [15:0] ez, input logic ec, input logic eo);
      checkOutput({tag, ".Z"}, {16'h0, z}, {16'h0, ez});
      checkOutput({tag, ".C_out"}, {31'h0, c_out}, {31'h0, ec});
      checkOutput({tag, ".ovf"}, {31'h0, ovf}, {31'h0, eo});
   endtask

   initial begin
      logic [15:0] ra, rb;
      logic        rc;
      logic [16:0] sum;
      int          ready_low;
      int          done_cnt;

      rst = 1'b1; start = 1'b0; x = '0; y = '0; c_in = 1'b0;
      start4 = 1'b0; x4 = '0; y4 = '0; c_in4 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst.ready", {31'h0, ready}, 32'd1);
      checkOutput("rst.done", {31'h0, done}, 32'd0);
      checkResult("rst", 16'h0000, 1'b0, 1'b0);

      applyStimulus(16'h0FFF, 16'h0001, 1'b0);
      checkResult("chain", 16'h1000, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("pulse.done", {31'h0, done}, 32'd0);
      checkOutput("pulse.ready", {31'h0, ready}, 32'd1);
      checkOutput("hold.Z", {16'h0, z}, 32'h1000);

      applyStimulus(16'hFFFF, 16'h0000, 1'b1);
      checkResult("wrapcin", 16'h0000, 1'b1, 1'b0);
      applyStimulus(16'h8000, 16'h8000, 1'b0);
      checkResult("negovf", 16'h0000, 1'b1, 1'b1);
      applyStimulus(16'h7FFF, 16'h0001, 1'b0);
      checkResult("posovf", 16'h8000, 1'b0, 1'b1);

      for (int i = 0; i < 4; i++) begin
         ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
         sum = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
         applyStimulus(ra, rb, rc);
         checkResult("model", sum[15:0], sum[16], (ra[15] == rb[15]) && (sum[15] != ra[15]));
      end

      // The reset is asynchronous, so it must clear the result between clock edges.
      @(negedge clk);
      #1 rst = 1'b1;
      #1 checkOutput("asyncrst.Z", {16'h0, z}, 32'h0);
      rst = 1'b0;

      // Keep start high and keep changing the operands; only the first request may be taken.
      @(negedge clk);
      x = 16'h1234; y = 16'h1111; c_in = 1'b0; start = 1'b1;
      ready_low = 0; done_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         x = 16'($urandom); y = 16'($urandom); c_in = 1'($urandom);
         if (!ready) ready_low++;
         if (done) begin
            done_cnt++;
            checkOutput("inflight.Z", {16'h0, z}, 32'h2345);
         end
      end
      @(negedge clk);
      start = 1'b0;
      if (!ready) ready_low++;
      if (done) done_cnt++;
      @(negedge clk);
      checkOutput("inflight.readylow", ready_low, 5);
      checkOutput("inflight.donecnt", done_cnt, 1);
      checkOutput("inflight.noreop", {31'h0, ready}, 32'd1);

      // Reset during the second ADD cycle must abandon the operation without a done pulse.
      @(negedge clk);
      x = 16'h1234; y = 16'h4321; c_in = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      checkOutput("abort.done", done_cnt, 0);
      checkOutput("abort.ready", {31'h0, ready}, 32'd1);
      checkResult("abort", 16'h0000, 1'b0, 1'b0);
      applyStimulus(16'h0001, 16'h0001, 1'b0);
      checkResult("afterabort", 16'h0002, 1'b0, 1'b0);

      // 4-bit instance: the whole operation takes a single ADD cycle.
      @(negedge clk);
      x4 = 4'hF; y4 = 4'h1; c_in4 = 1'b0; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      cycles = 0;
      while (!done4 && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("n4.latency", cycles, 1);
      checkOutput("n4.Z", {28'h0, z4}, 32'h0);
      checkOutput("n4.C_out", {31'h0, c_out4}, 32'd1);
      checkOutput("n4.ovf", {31'h0, ovf4}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
